spi_master_cfg: RTL and testbench

//  Parametrised full-duplex SPI master; successor to the fixed 12-bit, mode-0, single-CS, MOSI-only master.

---
 rtl/spi_master_cfg.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_master_cfg.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// -----------------------------------------------------------------------------
// spi_master_cfg
//   Full-duplex SPI master with a configurable word width, SCLK divider,
//   number of chip selects and all four CPOL/CPHA modes.
//   A start request (newd) is taken only in IDLE. At that point the transmit
//   word, the clock mode and the slave index are latched. The transfer then
//   runs through SETUP -> XFER -> HOLD -> DONE and returns to IDLE.
//
//   Optional feature macro: SPI_MASTER_CFG_LSB_FIRST_EN
//     defined     : adds input lsb_first, latched on accept (1 = LSB first)
//     not defined : always MSB first
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   newd      in   start request, sampled only in IDLE
//   din       in   transmit word, latched on accept
//   cpol      in   SCLK idle level, latched on accept
//   cpha      in   0: sample on leading edge, 1: sample on trailing edge
//   lsb_first in   (only with SPI_MASTER_CFG_LSB_FIRST_EN) bit order select
//   cs_sel    in   slave index, latched on accept
//   miso      in   serial data from slave
//   sclk      out  SPI clock
//   cs_n      out  active-low chip selects
//   mosi      out  serial data to slave
//   busy      out  high from the cycle after accept through DONE
//   done      out  one-cycle pulse, dout valid
//   dout      out  received word, held until the next done
// -----------------------------------------------------------------------------
module spi_master_cfg #(
    parameter int  DATA_W  = 12,
    parameter int  CLK_DIV = 4,
    parameter int  NUM_CS  = 1,
    localparam int SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic              miso,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    localparam int CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W    = $clog2(2 * DATA_W + 1);
    localparam int LAST_EDGE = 2 * DATA_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;      // cycles within the current half-period
    logic [EDGE_W-1:0]  edge_q, edge_d;    // SCLK edges already produced in XFER
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [DATA_W-1:0]  tx_q, tx_d;        // bits still to be sent, next one at the out end
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               lsb_q, lsb_d;
    logic               lsb_in;

`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // LSB-first shifts in from the top so the first sampled bit ends in bit 0.
    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] w, input logic lsb,
                                                   input logic b);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    logic phase_end;
    logic leading;

    assign phase_end = (cnt_q == CNT_W'(CLK_DIV - 1));
    // edge_q counts edges already made, so the coming edge is odd (leading) when edge_q is even.
    assign leading   = ~edge_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sel_q   <= '0;
            lsb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            sel_q   <= sel_d;
            lsb_q   <= lsb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        sel_d   = sel_q;
        lsb_d   = lsb_q;

        case (state_q)
            ST_IDLE: begin
                if (newd) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    rx_d    = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    sel_d   = cs_sel;
                    lsb_d   = lsb_in;
                    sclk_d  = cpol;
                    if (cpha) begin
                        // First bit goes out on the first leading edge.
                        mosi_d = 1'b0;
                        tx_d   = din;
                    end else begin
                        // First bit must be valid before the first leading edge.
                        mosi_d = first_bit(din, lsb_in);
                        tx_d   = shift_tx(din, lsb_in);
                    end
                end
            end

            ST_SETUP: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_XFER: begin
                if (phase_end) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (leading ^ cpha_q) begin
                        // Sample edge: leading for cpha=0, trailing for cpha=1.
                        rx_d = shift_rx(rx_q, lsb_q, miso);
                    end else if (cpha_q || (edge_q != EDGE_W'(LAST_EDGE))) begin
                        // Shift edge; in cpha=0 the final trailing edge keeps the last bit.
                        mosi_d = first_bit(tx_q, lsb_q);
                        tx_d   = shift_tx(tx_q, lsb_q);
                    end
                    if (edge_q == EDGE_W'(LAST_EDGE)) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    dout_d  = rx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                mosi_d  = 1'b0;
                sclk_d  = cpol_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic cs_active;
    assign cs_active = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);

    // An out-of-range sel_q matches no index, so every select stays high.
    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign cs_n[gi] = ~(cs_active && (sel_q == SEL_W'(gi)));
        end
    endgenerate

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign dout = dout_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// -----------------------------------------------------------------------------
// tb_spi_master_cfg
//   Bench for spi_master_cfg (DATA_W=12, CLK_DIV=2). The main instance has
//   NUM_CS=4. A second instance with NUM_CS=3 covers the out-of-range cs_sel case.
//   Each accepted transfer pushes its expected dout, the word the slave should
//   receive, and the cs_n pattern onto a queue. A negedge monitor pops the queue
//   on every done pulse. The same monitor contains a mode-aware slave model.
// -----------------------------------------------------------------------------
module tb_spi_master_cfg;

    localparam int DW    = 12;
    localparam int CD    = 2;
    localparam int LAT   = CD * (2 * DW + 2) + 1;   // 53
    localparam int EDGES = 2 * DW;                  // 24

    typedef struct packed {
        logic [11:0] dout_w;
        logic [11:0] mosi_w;
        logic [3:0]  cs_w;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    = 1'b1;
    logic        newd   = 1'b0;
    logic [11:0] din    = '0;
    logic        cpol   = 1'b0;
    logic        cpha   = 1'b0;
    logic [1:0]  cs_sel = '0;
    logic        miso;
    logic        sclk, mosi, busy, done;
    logic [3:0]  cs_n;
    logic [11:0] dout;

    logic        newd3   = 1'b0;
    logic [11:0] din3    = '0;
    logic [1:0]  cs_sel3 = '0;
    logic        cpol3   = 1'b0;
    logic        cpha3   = 1'b0;
    logic        miso3;
    logic        sclk3, mosi3, busy3, done3;
    logic [2:0]  cs_n3;
    logic [11:0] dout3;

`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
    logic        lsb_first = 1'b0;
`endif

    // Slave model configuration.
    logic        cpol_m = 1'b0, cpha_m = 1'b0, loop_m = 1'b1;
    logic [11:0] slave_word_m = '0;
    logic        slave_miso = 1'b0;
    logic [11:0] sh = '0, srx = '0;

    assign miso  = loop_m ? mosi : slave_miso;
    assign miso3 = mosi3;

    spi_master_cfg #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(4)) dut (
        .clk(clk), .rst(rst), .newd(newd), .din(din), .cpol(cpol), .cpha(cpha),
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .cs_sel(cs_sel), .miso(miso), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .busy(busy), .done(done), .dout(dout)
    );

    spi_master_cfg #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(3)) dut3 (
        .clk(clk), .rst(rst), .newd(newd3), .din(din3), .cpol(cpol3), .cpha(cpha3),
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .cs_sel(cs_sel3), .miso(miso3), .sclk(sclk3), .cs_n(cs_n3), .mosi(mosi3),
        .busy(busy3), .done(done3), .dout(dout3)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   gap_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor + slave model (negedge, outputs stable).
    int         cyc = 0, start_cyc = 0, last_done_cyc = 0, edges = 0;
    int         done_cnt = 0, rise_cnt = 0;
    logic       busy_prev = 1'b0, prev_sclk = 1'b0, lead;
    logic [3:0] cs_and = '1, cs_or = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !busy_prev) begin
                gap_q.push_back(cyc - last_done_cyc);
                rise_cnt++;
                start_cyc = cyc;
                edges     = 0;
                prev_sclk = sclk;
                cs_and    = '1;
                cs_or     = '0;
                sh        = slave_word_m;
                srx       = '0;
                if (!cpha_m) begin
                    slave_miso = sh[11];
                    sh         = sh << 1;
                end
            end else if (busy && !done) begin
                if (sclk != prev_sclk) begin
                    edges++;
                    lead = (prev_sclk == cpol_m);
                    if (lead ^ cpha_m) begin
                        srx = {srx[10:0], mosi};
                    end else begin
                        slave_miso = sh[11];
                        sh         = sh << 1;
                    end
                end
                prev_sclk = sclk;
            end
            if (busy && !done) begin
                cs_and = cs_and & cs_n;
                cs_or  = cs_or | cs_n;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer %0d: dout=%h exp=%h slave_rx=%h exp=%h latency=%0d edges=%0d",
                             done_cnt, dout, e.dout_w, srx, e.mosi_w, cyc - start_cyc + 1, edges);
                    check("dout", 32'(dout), 32'(e.dout_w));
                    check("slave_rx", 32'(srx), 32'(e.mosi_w));
                    check("latency", 32'(cyc - start_cyc + 1), 32'(LAT));
                    check("edges", 32'(edges), 32'(EDGES));
                    check("cs_and", 32'(cs_and), 32'(e.cs_w));
                    check("cs_or", 32'(cs_or), 32'(e.cs_w));
                    check("cs_done", 32'(cs_n), 32'hF);
                end
                done_cnt++;
                last_done_cyc = cyc;
            end
            busy_prev = busy;
        end
    end

    task automatic start_xfer(input logic [11:0] d, input logic pol, input logic pha,
                              input logic [1:0] sel, input logic [11:0] sw, input logic lp,
                              input logic push);
        exp_t e;
        @(negedge clk);
        cpol_m = pol; cpha_m = pha; loop_m = lp; slave_word_m = sw;
        din = d; cpol = pol; cpha = pha; cs_sel = sel; newd = 1'b1;
        if (push) begin
            e.dout_w = lp ? d : sw;
            e.mosi_w = d;
            e.cs_w   = ~(4'b0001 << sel);
            exp_q.push_back(e);
        end
        @(negedge clk);
        newd = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && done_cnt < target; i++) @(negedge clk);
        if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rb, t;
        logic [2:0]  c3_and, c3_or;
        logic [1:0]  sel3_tab [2];
        logic [2:0]  cs3_tab  [2];
        logic [11:0] d3_tab   [2];
        sel3_tab[0] = 2'd3; cs3_tab[0] = 3'b111; d3_tab[0] = 12'h5E7;
        sel3_tab[1] = 2'd1; cs3_tab[1] = 3'b101; d3_tab[1] = 12'hC3A;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'hF);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);

        // Mode 0 loopback.
        start_xfer(12'hA5C, 1'b0, 1'b0, 2'd2, 12'h000, 1'b1, 1'b1);
        wait_done(1);

        // Mode 3 with slave word.
        start_xfer(12'hFFF, 1'b1, 1'b1, 2'd0, 12'h3C1, 1'b0, 1'b1);
        wait_done(2);
        @(negedge clk);
        cpol = 1'b0;                       // IDLE changes must not reach sclk
        repeat (3) @(negedge clk);
        check("idle_sclk_cpol1", 32'(sclk), 32'd1);
        check("idle_mosi", 32'(mosi), 32'd0);

        // Modes 1 and 2 with slave model.
        start_xfer(12'h801, 1'b0, 1'b1, 2'd1, 12'h5A3, 1'b0, 1'b1);
        wait_done(3);
        start_xfer(12'h801, 1'b1, 1'b0, 2'd3, 12'h1E7, 1'b0, 1'b1);
        wait_done(4);

        // Reset during XFER.
        base = done_cnt;
        start_xfer(12'h3A7, 1'b1, 1'b0, 2'd1, 12'h000, 1'b1, 1'b0);
        for (int i = 0; i < 200 && edges < 10; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cs_n", 32'(cs_n), 32'hF);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (60) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(base));
        start_xfer(12'h6B2, 1'b0, 1'b1, 2'd2, 12'h2D4, 1'b0, 1'b1);
        wait_done(base + 1);

        // newd held high for three words, plus a stray pulse while busy.
        repeat (2) @(negedge clk);
        base = done_cnt;
        rb   = rise_cnt;
        gap_q.delete();
        cpol_m = 1'b0; cpha_m = 1'b0; loop_m = 1'b1;
        din = 12'h9C3; cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0;
        for (int i = 0; i < 3; i++) exp_q.push_back('{12'h9C3, 12'h9C3, 4'b1110});
        newd = 1'b1;
        for (int i = 0; i < 400 && rise_cnt < rb + 3; i++) @(negedge clk);
        newd = 1'b0;
        if (rise_cnt < rb + 3) check("rise_timeout", 32'(rise_cnt), 32'(rb + 3));
        repeat (10) @(negedge clk);
        newd = 1'b1;
        @(negedge clk);
        newd = 1'b0;
        wait_done(base + 3);
        repeat (120) @(negedge clk);
        check("three_done", 32'(done_cnt - base), 32'd3);
        check("gap_count", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() == 3) begin
            check("gap1", 32'(gap_q[1]), 32'd2);
            check("gap2", 32'(gap_q[2]), 32'd2);
        end

        // NUM_CS=3 instance: out-of-range and in-range select.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            din3 = d3_tab[k]; cs_sel3 = sel3_tab[k]; newd3 = 1'b1;
            @(negedge clk);
            newd3  = 1'b0;
            t      = 1;
            c3_and = '1;
            c3_or  = '0;
            for (int i = 0; i < 200 && !done3; i++) begin
                c3_and = c3_and & cs_n3;
                c3_or  = c3_or | cs_n3;
                @(negedge clk);
                t++;
            end
            $display("cs3 xfer sel=%0d: dout3=%h exp=%h latency=%0d cs_n3 and=%b or=%b",
                     sel3_tab[k], dout3, d3_tab[k], t, c3_and, c3_or);
            check("cs3_done_seen", 32'(done3), 32'd1);
            check("cs3_latency", 32'(t), 32'(LAT));
            check("cs3_dout", 32'(dout3), 32'(d3_tab[k]));
            check("cs3_and", 32'(c3_and), 32'(cs3_tab[k]));
            check("cs3_or", 32'(c3_or), 32'(cs3_tab[k]));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
